// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: grants one of NUM_REQ sources per cycle and
// registers a one-hot write enable plus data. Define RF_WB_FIXED_PRIO_EN for fixed priority.
module rf_wb_arbiter #(
  parameter  int NUM_REQ = 3,
  parameter  int DATA_W  = 32,
  parameter  int ADDR_W  = 5,
  localparam int PTR_W   = $clog2(NUM_REQ),
  localparam int NREG    = 1 << ADDR_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wb_stall,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NREG-1:0]           rf_we,
  output logic [DATA_W-1:0]         rf_wdata,
  output logic [ADDR_W-1:0]         rf_waddr,
  output logic                      wr_fire,
  output logic [PTR_W-1:0]          last_grant
);

  logic              found;
  logic              xfer;
  logic [PTR_W-1:0]  gnt_idx;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_data;

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
`ifdef RF_WB_FIXED_PRIO_EN
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i]) begin
        found   = 1'b1;
        gnt_idx = PTR_W'(i);
      end
    end
`else
    // Two passes give the wrap explicitly: indices above the pointer first,
    // then 0..last_grant, so no index >= NUM_REQ can ever be selected.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && (i > int'(last_grant))) begin
        found   = 1'b1;
        gnt_idx = PTR_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && (i <= int'(last_grant))) begin
        found   = 1'b1;
        gnt_idx = PTR_W'(i);
      end
    end
`endif
    xfer      = found && !wb_stall && reset;
    req_ready = xfer ? (NUM_REQ'(1) << gnt_idx) : '0;
  end

  always_comb begin
    gnt_addr = '0;
    gnt_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == PTR_W'(i)) begin
        gnt_addr = req_addr[i*ADDR_W +: ADDR_W];
        gnt_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // x0 writes are still accepted and consume a grant, but never raise an enable.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rf_we      <= '0;
      rf_wdata   <= '0;
      rf_waddr   <= '0;
      wr_fire    <= 1'b0;
      last_grant <= PTR_W'(NUM_REQ - 1);
    end else if (xfer) begin
      last_grant <= gnt_idx;
      rf_wdata   <= gnt_data;
      rf_waddr   <= gnt_addr;
      wr_fire    <= (gnt_addr != '0);
      rf_we      <= (gnt_addr != '0) ? (NREG'(1) << gnt_addr) : '0;
    end else begin
      rf_we   <= '0;
      wr_fire <= 1'b0;
    end
  end

endmodule
